// File: rtl/bldc_duty_integrator_if.sv
// Error-in / duty-out bundle between the speed subtractor, the duty integrator and the PWM stage.
// master: controller side driving errors; slave: the integrator.
interface bldc_duty_integrator_if;
    logic       clr;
    logic [8:0] err;
    logic       err_ofl;
    logic       err_vld;
    logic [7:0] duty;
    logic       duty_vld;
    logic       busy;
    logic       err_drop;

    modport master (
        output clr, err, err_ofl, err_vld,
        input  duty, duty_vld, busy, err_drop
    );

    modport slave (
        input  clr, err, err_ofl, err_vld,
        output duty, duty_vld, busy, err_drop
    );
endinterface

// File: rtl/bldc_duty_integrator.sv
// Integral stage: overflow-corrects, scales and accumulates speed error into a clamped 8-bit duty.
// Optional small-error deadband is compiled in with `define DUTY_INT_DEADBAND_EN.
module bldc_duty_integrator #(
    parameter int unsigned KI_SHIFT = 2,
    parameter int unsigned DUTY_MAX = 250,
    parameter int unsigned DEADBAND = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    bldc_duty_integrator_if.slave      bus
);

    if (KI_SHIFT > 4 || DUTY_MAX > 255 || DEADBAND > 255) begin : g_bad_param
        $error("bldc_duty_integrator: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        SCALE,
        ACCUM,
        OUT
    } state_t;

    localparam logic signed [13:0] ACC_MAX = 14'(DUTY_MAX * 16);

    state_t             state;
    state_t             state_nxt;
    logic signed [8:0]  e_corr;
    logic signed [8:0]  e_r;
    logic signed [8:0]  q_r;
    logic signed [12:0] acc;
    logic signed [12:0] acc_nxt;
    logic signed [13:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.err_vld) state_nxt = SCALE;
            SCALE:   state_nxt = ACCUM;
            ACCUM:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.clr) state_nxt = IDLE;
    end

    // On overflow the subtractor's sign bit is inverted, so saturate to the true sign.
    always_comb begin
        e_corr = $signed(bus.err);
        if (bus.err_ofl) begin
            e_corr = bus.err[8] ? 9'sd255 : 9'h100;
        end
`ifdef DUTY_INT_DEADBAND_EN
        else if ($signed(bus.err) <= $signed(9'(DEADBAND)) &&
                 $signed(bus.err) >= -$signed(9'(DEADBAND))) begin
            e_corr = '0;
        end
`endif
    end

    // Sum is one bit wider than ACC so KI_SHIFT=0 near the ceiling cannot wrap before clamping.
    always_comb begin
        sum     = {acc[12], acc} + {{5{q_r[8]}}, q_r};
        acc_nxt = sum[12:0];
        if (sum < 0) begin
            acc_nxt = '0;
        end else if (sum > ACC_MAX) begin
            acc_nxt = ACC_MAX[12:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_r <= '0;
            q_r <= '0;
            acc <= '0;
        end else if (bus.clr) begin
            acc <= '0;
        end else begin
            unique case (state)
                IDLE:    if (bus.err_vld) e_r <= e_corr;
                SCALE:   q_r <= e_r >>> KI_SHIFT;
                ACCUM:   acc <= acc_nxt;
                default: ;
            endcase
        end
    end

    assign bus.duty     = acc[11:4];
    assign bus.duty_vld = (state == OUT);
    assign bus.busy     = (state != IDLE);
    assign bus.err_drop = !rst && bus.err_vld && ((state != IDLE) || bus.clr);

endmodule

// File: tb/tb_bldc_duty_integrator.sv
// Directed bench for bldc_duty_integrator with a duty/latency scoreboard.
module tb_bldc_duty_integrator;
    localparam int unsigned KI   = 2;
    localparam int unsigned DMAX = 250;
    localparam int unsigned DB   = 2;
    localparam int          AMAX = DMAX * 16;

    typedef struct {
        int duty;
        int at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   macc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bldc_duty_integrator_if itf();

    bldc_duty_integrator #(
        .KI_SHIFT (KI),
        .DUTY_MAX (DMAX),
        .DEADBAND (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (itf.slave)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic [8:0] e, input logic o);
        int ev;
        int q;
        int d;
        if (o) ev = e[8] ? 255 : -256;
        else   ev = e[8] ? int'(e) - 512 : int'(e);
`ifdef DUTY_INT_DEADBAND_EN
        if (!o && ev >= -int'(DB) && ev <= int'(DB)) ev = 0;
`endif
        d = 1 << KI;
        q = (ev >= 0) ? ev / d : -((-ev + d - 1) / d);
        macc = macc + q;
        if (macc < 0)    macc = 0;
        if (macc > AMAX) macc = AMAX;
    endtask

    // Presents one sample for the accepting edge; returns at the negedge after it.
    task automatic send(input logic [8:0] e, input logic o, input bit live);
        exp_t x;
        itf.err     = e;
        itf.err_ofl = o;
        itf.err_vld = 1'b1;
        if (live) begin
            model_step(e, o);
            x.duty = macc / 16;
            x.at   = cyc + 3;
            sb.push_back(x);
        end
        tick;
        itf.err_vld = 1'b0;
        itf.err     = 9'($urandom);
        itf.err_ofl = 1'($urandom);
        @(negedge clk);
        check("busy_after_accept", itf.busy, 1);
    endtask

    task automatic sample(input logic [8:0] e, input logic o);
        send(e, o, 1'b1);
        repeat (3) tick;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (itf.duty_vld === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_duty_vld", 1, 0);
            end else begin
                x = sb.pop_front();
                check("duty", itf.duty, 16'(x.duty));
                check("duty_vld_latency", 16'(cyc), 16'(x.at));
                check("duty_le_max", 16'(itf.duty <= 8'(DMAX)), 1);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        itf.clr     = 1'b0;
        itf.err     = '0;
        itf.err_ofl = 1'b0;
        itf.err_vld = 1'b0;
        tick;
        tick;
        @(negedge clk);
        check("rst_duty", itf.duty, 0);
        check("rst_duty_vld", itf.duty_vld, 0);
        check("rst_busy", itf.busy, 0);
        check("rst_err_drop", itf.err_drop, 0);
        rst = 1'b0;
        tick;

        sample(9'h040, 1'b0);
        sample(9'h1FC, 1'b0);

        itf.clr = 1'b1;
        tick;
        itf.clr = 1'b0;
        macc = 0;
        sample(9'h1F7, 1'b0);
        @(negedge clk);
        check("neg_clamp_duty", itf.duty, 0);

        sample(9'h100, 1'b1);
        sample(9'h0FF, 1'b1);

        for (int i = 0; i < 70; i++) sample(9'h0FF, 1'b0);
        tick;
        check("sat_duty", itf.duty, 16'(DMAX));

        // Drop: second strobe two cycles after acceptance.
        send(9'h1C0, 1'b0, 1'b1);
        tick;
        itf.err_vld = 1'b1;
        @(negedge clk);
        check("err_drop_busy", itf.err_drop, 1);
        tick;
        itf.err_vld = 1'b0;
        tick;
        @(negedge clk);
        check("idle_after_drop", itf.busy, 0);
        tick;

        // Clear during ACCUM, with a colliding strobe.
        send(9'h028, 1'b0, 1'b0);
        tick;
        itf.clr     = 1'b1;
        itf.err_vld = 1'b1;
        @(negedge clk);
        check("err_drop_clr", itf.err_drop, 1);
        tick;
        itf.clr     = 1'b0;
        itf.err_vld = 1'b0;
        macc = 0;
        @(negedge clk);
        check("clr_duty", itf.duty, 0);
        check("clr_busy", itf.busy, 0);
        check("clr_duty_vld", itf.duty_vld, 0);
        repeat (2) tick;

        // Reset mid-operation.
        sample(9'h040, 1'b0);
        send(9'h040, 1'b0, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        macc = 0;
        @(negedge clk);
        check("rst_mid_duty", itf.duty, 0);
        check("rst_mid_busy", itf.busy, 0);
        check("rst_mid_duty_vld", itf.duty_vld, 0);
        tick;

        sample(9'h040, 1'b0);
        sample(9'h002, 1'b0);
        sample(9'h003, 1'b0);
        sample(9'h1FD, 1'b0);
        sample(9'h1FE, 1'b0);

        repeat (4) tick;
        check("scoreboard_drained", 16'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
